exe_stage: RTL

- Execute-stage consumer of the ID/EXE pipeline register outputs: ewreg, em2reg, ewmem, ealuc, ealuimm, edestReg, eqa, eqb, eimm32.
- Selects operand B, runs single-cycle ALU ops or an iterative 32-cycle shift-add multiply, and registers results into the EXE/MEM pipeline register.
- During a multiply it asserts stall. The PC, IF/ID and ID/EXE registers hold while stall is high.

---
 rtl/exe_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// Execute stage: operand-B mux, single-cycle ALU and a 32-iteration shift-add
// multiplier, feeding the EXE/MEM pipeline register. Holds upstream via stall.
module exe_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic [3:0]  ealuc,
  input  logic        ealuimm,
  input  logic [4:0]  edestReg,
  input  logic [31:0] eqa,
  input  logic [31:0] eqb,
  input  logic [31:0] eimm32,
  output logic        mwreg,
  output logic        mm2reg,
  output logic        mwmem,
  output logic [4:0]  mdestReg,
  output logic [31:0] mr,
  output logic [31:0] mqb,
  output logic        stall
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam int CW = $clog2(MUL_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   mcand_q, mcand_d;
  logic [31:0]   mplier_q, mplier_d;
  logic [31:0]   acc_q, acc_d;
  logic          mwreg_q, mwreg_d;
  logic          mm2reg_q, mm2reg_d;
  logic          mwmem_q, mwmem_d;
  logic [4:0]    mdest_q, mdest_d;
  logic [31:0]   mr_q, mr_d;
  logic [31:0]   mqb_q, mqb_d;
  logic          stall_raw;
  logic [31:0]   b;
  logic [31:0]   alu_res;

  assign b = ealuimm ? eimm32 : eqb;

  always_comb begin
    alu_res = 32'd0;
    case (ealuc)
      ALU_AND: alu_res = eqa & b;
      ALU_OR:  alu_res = eqa | b;
      ALU_ADD: alu_res = eqa + b;
      ALU_SUB: alu_res = eqa - b;
      ALU_SLT: alu_res = ($signed(eqa) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_NOR: alu_res = ~(eqa | b);
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    mwreg_d   = mwreg_q;
    mm2reg_d  = mm2reg_q;
    mwmem_d   = mwmem_q;
    mdest_d   = mdest_q;
    mr_d      = mr_q;
    mqb_d     = mqb_q;
    stall_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (ealuc == ALU_MUL) begin
          stall_raw = 1'b1;
          mcand_d   = eqa;
          mplier_d  = b;
          acc_d     = 32'd0;
          cnt_d     = '0;
          state_d   = BUSY;
          mwreg_d   = 1'b0;
          mm2reg_d  = 1'b0;
          mwmem_d   = 1'b0;
        end else begin
          mwreg_d  = ewreg;
          mm2reg_d = em2reg;
          mwmem_d  = ewmem;
          mdest_d  = edestReg;
          mr_d     = alu_res;
          mqb_d    = eqb;
        end
      end
      BUSY: begin
        stall_raw = 1'b1;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        mwreg_d  = 1'b0;
        mm2reg_d = 1'b0;
        mwmem_d  = 1'b0;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        // Going to IDLE (not re-checking ealuc) keeps the held MUL from restarting.
        mwreg_d  = ewreg;
        mm2reg_d = em2reg;
        mwmem_d  = ewmem;
        mdest_d  = edestReg;
        mr_d     = acc_q;
        mqb_d    = eqb;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
      mwreg_q  <= 1'b0;
      mm2reg_q <= 1'b0;
      mwmem_q  <= 1'b0;
      mdest_q  <= 5'd0;
      mr_q     <= 32'd0;
      mqb_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      mwreg_q  <= mwreg_d;
      mm2reg_q <= mm2reg_d;
      mwmem_q  <= mwmem_d;
      mdest_q  <= mdest_d;
      mr_q     <= mr_d;
      mqb_q    <= mqb_d;
    end
  end

  // Reset forces stall low even if a MUL is sitting on the inputs.
  assign stall    = stall_raw & ~reset;
  assign mwreg    = mwreg_q;
  assign mm2reg   = mm2reg_q;
  assign mwmem    = mwmem_q;
  assign mdestReg = mdest_q;
  assign mr       = mr_q;
  assign mqb      = mqb_q;

endmodule
